// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: general-purpose register bank with one shared write port,
// round-robin arbitrated between the execute-stage writeback (requester 0)
// and the load-unit writeback (requester 1), plus two combinational read ports.
// Register 0 is hardwired to zero.
// Optional feature: define REG_BANK_BYPASS_EN to forward the winning write
// data to a read port that addresses the register being written this cycle.
module reg_bank_arbiter #(
  parameter  int NUM_REGS   = 8,
  parameter  int DATA_WIDTH = 16,
  localparam int AW         = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [AW-1:0]         addr0,
  input  logic [DATA_WIDTH-1:0] data0,
  output logic                  gnt0,
  input  logic                  req1,
  input  logic [AW-1:0]         addr1,
  input  logic [DATA_WIDTH-1:0] data1,
  output logic                  gnt1,
  input  logic [AW-1:0]         rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [AW-1:0]         rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  last_gnt
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_last_gnt;

  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_wr_en;
  logic [AW-1:0]         w_wr_addr;
  logic [DATA_WIDTH-1:0] w_wr_data;

  // Round-robin grant: a lone requester wins; on contention the requester
  // that was not granted last wins. Grants are suppressed while in reset.
  always_comb begin
    w_gnt0 = reset & req0 & (~req1 | r_last_gnt);
    w_gnt1 = reset & req1 & (~req0 | ~r_last_gnt);
  end

  // Select the winning requester's write address and data.
  always_comb begin
    w_wr_en   = w_gnt0 | w_gnt1;
    w_wr_addr = w_gnt1 ? addr1 : addr0;
    w_wr_data = w_gnt1 ? data1 : data0;
  end

  // Register storage; register 0 is never written so it stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_wr_addr == AW'(i)) begin
          r_regs[i] <= w_wr_data;
        end
      end
    end
  end

  // Round-robin pointer; resets to 1 so requester 0 wins first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_gnt <= 1'b1;
    end else if (w_wr_en) begin
      r_last_gnt <= w_gnt1;
    end
  end

  // Read port A: zero for register 0, optional forwarding of the live write.
  always_comb begin
    rd_data_a = (rd_addr_a == '0) ? '0 : r_regs[rd_addr_a];
`ifdef REG_BANK_BYPASS_EN
    if (w_wr_en && (w_wr_addr != '0) && (w_wr_addr == rd_addr_a)) begin
      rd_data_a = w_wr_data;
    end
`else
`endif
  end

  // Read port B: same behaviour as port A.
  always_comb begin
    rd_data_b = (rd_addr_b == '0) ? '0 : r_regs[rd_addr_b];
`ifdef REG_BANK_BYPASS_EN
    if (w_wr_en && (w_wr_addr != '0) && (w_wr_addr == rd_addr_b)) begin
      rd_data_b = w_wr_data;
    end
`else
`endif
  end

  assign gnt0     = w_gnt0;
  assign gnt1     = w_gnt1;
  assign last_gnt = r_last_gnt;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Testbench for reg_bank_arbiter: directed writeback scenarios with a
// behavioural register-file model checked on every falling clock edge.
module tb_reg_bank_arbiter;

  localparam int NUM_REGS   = 8;
  localparam int DATA_WIDTH = 16;
  localparam int AW         = 3;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0]         addr0 = '0, addr1 = '0, rd_addr_a = '0, rd_addr_b = '0;
  logic [DATA_WIDTH-1:0] data0 = '0, data1 = '0;
  logic                  gnt0, gnt1, last_gnt;
  logic [DATA_WIDTH-1:0] rd_data_a, rd_data_b;

  int checks   = 0;
  int failures = 0;

  // Model state: plain array of register values and the last winner index.
  int mregs [NUM_REGS];
  int mlast = 1;

  reg_bank_arbiter #(.NUM_REGS(NUM_REGS), .DATA_WIDTH(DATA_WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
    .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .last_gnt(last_gnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Who wins this cycle: -1 none, else requester index.
  function automatic int winner();
    if (!reset) return -1;
    if (req0 && req1) return (mlast == 1) ? 0 : 1;
    if (req0) return 0;
    if (req1) return 1;
    return -1;
  endfunction

  function automatic int exp_rd(input int a);
    int w;
    if (a == 0) return 0;
    w = winner();
`ifdef REG_BANK_BYPASS_EN
    if (w == 0 && int'(addr0) == a) return int'(data0);
    if (w == 1 && int'(addr1) == a) return int'(data1);
`else
`endif
    return mregs[a];
  endfunction

  // Model update: async clear, otherwise commit the winner's write.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) mregs[i] = 0;
      mlast = 1;
    end else begin
      int w;
      w = winner();
      if (w == 0) begin
        if (addr0 != 0) mregs[addr0] = int'(data0);
        mlast = 0;
      end else if (w == 1) begin
        if (addr1 != 0) mregs[addr1] = int'(data1);
        mlast = 1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    int w;
    w = winner();
    chk("m_gnt0", 32'(gnt0), 32'(w == 0));
    chk("m_gnt1", 32'(gnt1), 32'(w == 1));
    chk("m_last_gnt", 32'(last_gnt), 32'(mlast));
    chk("m_rd_a", 32'(rd_data_a), 32'(exp_rd(int'(rd_addr_a))));
    chk("m_rd_b", 32'(rd_data_b), 32'(exp_rd(int'(rd_addr_b))));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  initial begin
    #2 reset = 1'b0;
    at_neg();
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_last", 32'(last_gnt), 32'd1);
    step(); reset = 1'b1;

    // Single requester to register 3.
    req0 = 1'b1; addr0 = 3'd3; data0 = 16'hBEEF; rd_addr_a = 3'd3;
    at_neg();
    chk("single_gnt0", 32'(gnt0), 32'd1);
    step(); req0 = 1'b0;
    at_neg();
    chk("single_rd", 32'(rd_data_a), 32'hBEEF);
    chk("single_last", 32'(last_gnt), 32'd0);

    // Mid-run asynchronous reset with a request present.
    step(); req0 = 1'b1; addr0 = 3'd7; data0 = 16'h7777; reset = 1'b0;
    at_neg();
    chk("midrst_gnt0", 32'(gnt0), 32'd0);
    chk("midrst_rd3", 32'(rd_data_a), 32'd0);
    chk("midrst_last", 32'(last_gnt), 32'd1);
    step(); req0 = 1'b0; reset = 1'b1;

    // Continuous contention: expect grants 0,1,0,1.
    req0 = 1'b1; addr0 = 3'd1; data0 = 16'h1111;
    req1 = 1'b1; addr1 = 3'd2; data1 = 16'h2222;
    rd_addr_a = 3'd1; rd_addr_b = 3'd2;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("cont_gnt0", 32'(gnt0), 32'((k % 2) == 0));
      chk("cont_gnt1", 32'(gnt1), 32'((k % 2) == 1));
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    at_neg();
    chk("cont_r1", 32'(rd_data_a), 32'h1111);
    chk("cont_r2", 32'(rd_data_b), 32'h2222);

    // Same-cycle write and read of register 5.
    step(); req0 = 1'b1; addr0 = 3'd5; data0 = 16'hA5A5; rd_addr_a = 3'd5;
    at_neg();
`ifdef REG_BANK_BYPASS_EN
    chk("bypass_rd", 32'(rd_data_a), 32'hA5A5);
`else
    chk("bypass_rd", 32'(rd_data_a), 32'h0);
`endif
    step(); req0 = 1'b0;
    at_neg();
    chk("after_wr_rd", 32'(rd_data_a), 32'hA5A5);

    // Write to register 0 is granted and discarded, never forwarded.
    step(); req1 = 1'b1; addr1 = 3'd0; data1 = 16'hFFFF; rd_addr_a = 3'd0; rd_addr_b = 3'd0;
    at_neg();
    chk("r0_gnt1", 32'(gnt1), 32'd1);
    chk("r0_rd_a", 32'(rd_data_a), 32'd0);
    step(); req1 = 1'b0;
    at_neg();
    chk("r0_rd_b", 32'(rd_data_b), 32'd0);

    // Async reset while req1 is pending and losing arbitration.
    step();
    req0 = 1'b1; addr0 = 3'd4; data0 = 16'h4444;
    req1 = 1'b1; addr1 = 3'd6; data1 = 16'h6666;
    at_neg();
    chk("pend_gnt0", 32'(gnt0), 32'd1);
    chk("pend_gnt1", 32'(gnt1), 32'd0);
    reset = 1'b0;
    req0 = 1'b0;
    step();
    at_neg();
    chk("pend_rst_gnt1", 32'(gnt1), 32'd0);
    step(); reset = 1'b1;
    at_neg();
    chk("pend_rel_gnt1", 32'(gnt1), 32'd1);
    step(); req1 = 1'b0; rd_addr_a = 3'd6; rd_addr_b = 3'd4;
    at_neg();
    chk("pend_r6", 32'(rd_data_a), 32'h6666);
    chk("pend_r4", 32'(rd_data_b), 32'h0);
    chk("pend_last", 32'(last_gnt), 32'd1);

    step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
# reg_bank_arbiter

Register bank with a shared write port arbitrated between two requesters and two asynchronous read ports. It sits between the execute stage (requester 0, ALU writeback) and the load unit (requester 1, memory writeback) and owns the processor's general-purpose 16-bit registers. It uses round-robin arbitration so neither writeback path can starve the other. An optional write-to-read bypass is available.

## Interface
- NUM_REGS, 8, number of registers; must be a power of two, 2..16; register 0 reads as zero.
- DATA_WIDTH, 16, register width in bits.
- AW is derived, not a parameter: AW = log2(NUM_REGS), 3 by default.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset: asserted when 0, released when 1.
- req0  in  1  requester 0 write request; held until granted.
- addr0  in  AW  requester 0 destination register.
- data0  in  DATA_WIDTH  requester 0 write data.
- gnt0  out  1  requester 0 granted this cycle; combinational.
- req1, addr1, data1, gnt1: same as above, for requester 1.
- rd_addr_a  in  AW  read port A address.
- rd_data_a  out  DATA_WIDTH  read port A data; combinational.
- rd_addr_b  in  AW  read port B address.
- rd_data_b  out  DATA_WIDTH  read port B data; combinational.
- last_gnt  out  1  round-robin pointer: index of the most recently granted requester.

## Operation
- Storage: NUM_REGS x DATA_WIDTH flops, all cleared by reset.
- Register 0 is hardwired to 0. Writes to it are granted and discarded.
- Arbitration is evaluated every cycle from req0, req1 and last_gnt:
  - Only one requester active: that requester is granted.
  - Both active: grant goes to the requester whose index differs from last_gnt.
  - Neither active: no grant; last_gnt holds.
- gnt0 and gnt1 are one-hot or zero. They are never both 1.
- On a rising edge with gntN=1:
  - regs[addrN] <= dataN, unless addrN = 0.
  - last_gnt <= N.
- Requester handshake:
  - The requester keeps reqN, addrN and dataN stable until it samples gntN=1 at a rising edge.
  - The transfer completes on that edge.
  - The requester may drop reqN, or present the next write, in the following cycle.
- Back-to-back requests from the same requester are granted every cycle while the other requester is idle.
- Under continuous contention, grants alternate 0,1,0,1...
- Read ports:
  - rd_data_x = regs[rd_addr_x], or 0 when rd_addr_x = 0.
  - Both ports may read the same address.
- A write and a read to the same register in the same cycle: see Configuration.

## Timing
- Reset (reset=0, asynchronous):
  - All registers = 0.
  - last_gnt = 1, so requester 0 wins the first contended cycle.
  - rd_data_a = rd_data_b = 0.
  - gnt0 and gnt1 are forced to 0 while reset is asserted.
- Reset is released synchronously to clk by the system. The first grant can occur in the first cycle after release.
- Reset during a pending request: the request is not completed. The requester must hold reqN through release and is then re-arbitrated.
- Grant latency: 0 cycles from reqN to gntN when uncontended. Worst case is 1 cycle under contention.
- Write latency: data is visible on read ports the cycle after the grant edge, unless bypass is compiled in.
- Read latency: 0 cycles (combinational from rd_addr_x).

## Configuration
- REG_BANK_BYPASS_EN defined:
  - If the current winner's address is nonzero and equals rd_addr_x, rd_data_x returns the winner's data in the same cycle.
  - This applies per port.
- REG_BANK_BYPASS_EN undefined:
  - rd_data_x shows the pre-write value in the grant cycle.
  - The new value appears from the cycle after the grant edge.

## Test plan
- Reset check: drive reset=0 mid-run, then release. Required: all reads return 0, last_gnt=1, gnt0=gnt1=0 during reset.
- Single requester: req0 with addr0=3, data0=0xBEEF. Required: gnt0=1 the same cycle; rd_data_a(addr 3)=0xBEEF the next cycle; last_gnt=0.
- Contention: req0 and req1 held high for 4 cycles after reset, addr0=1/data0=0x1111, addr1=2/data1=0x2222. Required: grant order 0,1,0,1; regs 1 and 2 hold the expected values.
- Register 0: req1 with addr1=0, data1=0xFFFF. Required: gnt1=1; rd_data_b(addr 0)=0 afterwards.
- Same-cycle read/write: req0 with addr0=5, data0=0xA5A5 while rd_addr_a=5 and the old value is 0. Required: rd_data_a=0xA5A5 in the grant cycle with REG_BANK_BYPASS_EN; 0 without; 0xA5A5 the next cycle in both builds.
- Async reset mid-request: assert reset while req1 is pending and ungranted, hold req1 through release. Required: gnt1 stays 0 during reset, goes to 1 on the first post-release cycle, and the write lands.
